// File: rtl/alpha_beta_search_ctrl_pkg.sv
// chess_pkg: piece ids, sides, search states and score range helpers shared by the search controller
package chess_pkg;
  localparam logic [3:0] P1 = 4'd1, N1 = 4'd2, B1 = 4'd3, R1 = 4'd4, Q1 = 4'd5, K1 = 4'd6;
  localparam logic BLACK = 1'b0, WHITE = 1'b1;
  typedef enum logic [2:0] {IDLE, NEXT, MAKE, EVAL, UNMAKE, RETURN, DONE} state_t;
  function automatic int score_max(int hw);
    return (1 << hw) - 1;
  endfunction
  function automatic int score_min(int hw);
    return -score_max(hw);
  endfunction
  // Clamping the one unrepresentable-when-negated value first keeps negation overflow free.
  function automatic int neg_clamp(int v, int hw);
    return (v < score_min(hw)) ? score_max(hw) : -v;
  endfunction
endpackage

// File: rtl/alpha_beta_search_ctrl_if.sv
// alpha_beta_search_ctrl_if: move generator, board make/unmake and evaluator handshakes
interface alpha_beta_search_ctrl_if #(parameter int HEUR_WIDTH = 10, MOVE_WIDTH = 6, PIECE_WIDTH = 4);
  logic gen_req, gen_valid, gen_end, gen_flush, make_req, unmake_req, board_ack, eval_req, eval_valid;
  logic [MOVE_WIDTH-1:0] gen_move;
  logic [PIECE_WIDTH-1:0] gen_piece;
  logic signed [HEUR_WIDTH:0] eval_score;
  modport master (output gen_req, gen_flush, make_req, unmake_req, eval_req,
                  input gen_valid, gen_end, gen_move, gen_piece, board_ack, eval_valid, eval_score);
  modport slave (input gen_req, gen_flush, make_req, unmake_req, eval_req,
                 output gen_valid, gen_end, gen_move, gen_piece, board_ack, eval_valid, eval_score);
endinterface

// File: rtl/alpha_beta_search_ctrl_ply_stack.sv
// ply_stack: per-ply search frames {alpha, beta, best, move, piece}, one async read and one sync write port
module ply_stack #(parameter int DEPTH = 5, SW = 11, MW = 6, PW = 4) (
  input  logic clk,
  input  logic RST,
  input  logic [2:0] ra,
  output logic signed [SW-1:0] r_alpha, r_beta, r_best,
  output logic [MW-1:0] r_move,
  output logic [PW-1:0] r_piece,
  input  logic we,
  input  logic [2:0] wa,
  input  logic signed [SW-1:0] w_alpha, w_beta, w_best,
  input  logic [MW-1:0] w_move,
  input  logic [PW-1:0] w_piece
);
  logic [3*SW+MW+PW-1:0] mem [DEPTH];
  assign {r_alpha, r_beta, r_best, r_move, r_piece} = mem[ra];
  // all frames clear on reset; at most one frame is rewritten per cycle
  always_ff @(posedge clk or posedge RST)
    if (RST) for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    else if (we) mem[wa] <= {w_alpha, w_beta, w_best, w_move, w_piece};
endmodule

// File: rtl/alpha_beta_search_ctrl.sv
// alpha_beta_search_ctrl: fixed-depth negamax alpha-beta search sequencer
module alpha_beta_search_ctrl import chess_pkg::*; #(
  parameter int HEUR_WIDTH = 10,
  parameter int MAX_DEPTH = 5,
  parameter int MOVE_WIDTH = 6,
  parameter int PIECE_WIDTH = 4,
  parameter int MATE_SCORE = 1000
) (
  input  logic clk,
  input  logic RST,
  input  logic en,
  input  logic pl,
  input  logic [2:0] depth_limit,
  alpha_beta_search_ctrl_if.master bus,
  output logic [2:0] cur_ply,
  output logic cur_side,
  output logic [PIECE_WIDTH-1:0] piece_to_move,
  output logic [MOVE_WIDTH-1:0] output_move,
  output logic signed [HEUR_WIDTH:0] best_value,
  output logic no_move,
  output logic [15:0] node_count,
  output logic done
);
  localparam int SW = HEUR_WIDTH + 1;
  localparam logic signed [SW-1:0] SMAX = SW'(score_max(HEUR_WIDTH));
  localparam logic signed [SW-1:0] SMIN = SW'(score_min(HEUR_WIDTH));
  localparam logic signed [SW-1:0] MATE = SW'(-MATE_SCORE);
  state_t state;
  logic [2:0] dlim, wa;
  logic pl_r, root_rec, start, push, cut, up_best, we;
  logic signed [SW-1:0] s, up_alpha, rd_alpha, rd_beta, rd_best, w_alpha, w_beta, w_best;
  logic [MOVE_WIDTH-1:0] rd_move, w_move;
  logic [PIECE_WIDTH-1:0] rd_piece, w_piece;
  ply_stack #(.DEPTH(MAX_DEPTH), .SW(SW), .MW(MOVE_WIDTH), .PW(PIECE_WIDTH)) u_stack (
    .clk(clk), .RST(RST), .ra(cur_ply),
    .r_alpha(rd_alpha), .r_beta(rd_beta), .r_best(rd_best), .r_move(rd_move), .r_piece(rd_piece),
    .we(we), .wa(wa), .w_alpha(w_alpha), .w_beta(w_beta), .w_best(w_best), .w_move(w_move), .w_piece(w_piece)
  );
  assign cur_side = pl_r ^ cur_ply[0];
  assign start = en && (state == IDLE || state == DONE);
  assign push = cur_ply + 3'd1 != dlim;
  assign up_best = s > rd_best;
  assign up_alpha = s > rd_alpha ? s : rd_alpha;
  assign cut = up_alpha >= rd_beta;
  // stack write: root init, move latch, mate fill, child push, or score update at the current ply
  always_comb begin
    we = 1'b0;
    wa = cur_ply;
    {w_alpha, w_beta, w_best, w_move, w_piece} = {rd_alpha, rd_beta, rd_best, rd_move, rd_piece};
    if (start) begin
      we = 1'b1;
      wa = 3'd0;
      {w_alpha, w_beta, w_best, w_move, w_piece} = {SMIN, SMAX, SMIN, {MOVE_WIDTH{1'b0}}, {PIECE_WIDTH{1'b0}}};
    end else if (state == NEXT && bus.gen_valid) begin
      we = 1'b1;
      w_move = bus.gen_move;
      w_piece = bus.gen_piece;
    end else if (state == NEXT && bus.gen_end) begin
      we = 1'b1;
      w_best = rd_best == SMIN ? MATE : rd_best;
    end else if (state == MAKE && bus.board_ack && push) begin
      we = 1'b1;
      wa = cur_ply + 3'd1;
      w_alpha = -rd_beta;
      w_beta = -rd_alpha;
      w_best = SMIN;
    end else if (state == UNMAKE && bus.board_ack) begin
      we = 1'b1;
      w_alpha = up_alpha;
      w_best = up_best ? s : rd_best;
    end
  end
  // search sequencer; each request rises on entry to its state and drops once answered
  always_ff @(posedge clk or posedge RST)
    if (RST) begin
      state <= IDLE;
      cur_ply <= '0;
      dlim <= '0;
      pl_r <= 1'b0;
      root_rec <= 1'b0;
      s <= '0;
      bus.gen_req <= 1'b0;
      bus.gen_flush <= 1'b0;
      bus.make_req <= 1'b0;
      bus.unmake_req <= 1'b0;
      bus.eval_req <= 1'b0;
      piece_to_move <= '0;
      output_move <= '0;
      best_value <= '0;
      no_move <= 1'b0;
      node_count <= '0;
      done <= 1'b0;
    end else begin
      bus.gen_flush <= 1'b0;
      if (start) begin
        state <= NEXT;
        bus.gen_req <= 1'b1;
        cur_ply <= '0;
        pl_r <= pl;
        dlim <= depth_limit == 3'd0 ? 3'd1 : depth_limit > 3'(MAX_DEPTH) ? 3'(MAX_DEPTH) : depth_limit;
        root_rec <= 1'b0;
        done <= 1'b0;
        no_move <= 1'b0;
        node_count <= '0;
        piece_to_move <= '0;
        output_move <= '0;
      end
      if (state == NEXT && (bus.gen_valid || bus.gen_end)) begin
        bus.gen_req <= 1'b0;
        bus.make_req <= bus.gen_valid;
        state <= bus.gen_valid ? MAKE : RETURN;
      end
      if (state == MAKE && bus.board_ack) begin
        bus.make_req <= 1'b0;
        node_count <= node_count + {15'd0, node_count != 16'hFFFF};
        bus.gen_req <= push;
        bus.eval_req <= !push;
        cur_ply <= push ? cur_ply + 3'd1 : cur_ply;
        state <= push ? NEXT : EVAL;
      end
      if (state == EVAL && bus.eval_valid) begin
        bus.eval_req <= 1'b0;
        bus.unmake_req <= 1'b1;
        s <= SW'(neg_clamp(int'(bus.eval_score), HEUR_WIDTH));
        state <= UNMAKE;
      end
      if (state == UNMAKE && bus.board_ack) begin
        bus.unmake_req <= 1'b0;
        if (up_best && cur_ply == 3'd0) begin
          root_rec <= 1'b1;
          piece_to_move <= rd_piece;
          output_move <= rd_move;
        end
        bus.gen_flush <= cut;
        bus.gen_req <= !cut;
        state <= cut ? RETURN : NEXT;
      end
      if (state == RETURN) begin
        if (cur_ply != 3'd0) begin
          s <= -rd_best;
          cur_ply <= cur_ply - 3'd1;
          bus.unmake_req <= 1'b1;
          state <= UNMAKE;
        end else begin
          best_value <= rd_best;
          no_move <= !root_rec;
          done <= 1'b1;
          state <= DONE;
        end
      end
    end
endmodule
